// File: rtl/key_filter_pkg.sv
// key_filter_pkg: shared channel state encoding and counter sizing helpers.
package key_filter_pkg;
  typedef enum logic [2:0] {IDLE, PRESS_FILTER, HELD, LONG_HELD, RELEASE_FILTER} state_t;
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int cnt_width(input int d, input int l, input int r);
    int m;
    m = (d > l) ? d : l;
    m = (m > r) ? m : r;
    return clog2(m);
  endfunction
endpackage

// File: rtl/key_filter_channel.sv
// key_filter_channel: synchroniser, debounce FSM and long-press/repeat timer for one key.
module key_filter_channel import key_filter_pkg::*; #(
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int LONG_CYC = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000,
  parameter int ACTIVE_LOW = 0,
  parameter int CW = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_state,
  output logic key_posedge,
  output logic key_negedge,
  output logic key_long,
  output logic key_repeat
);
  logic raw, s1, s2;
  state_t state, origin;
  logic [CW-1:0] cnt;
  assign raw = (ACTIVE_LOW != 0) ? ~key_in : key_in;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      origin <= IDLE;
      cnt <= '0;
      key_state <= 1'b0;
      key_posedge <= 1'b0;
      key_negedge <= 1'b0;
      key_long <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      key_posedge <= 1'b0;
      key_negedge <= 1'b0;
      key_long <= 1'b0;
      key_repeat <= 1'b0;
      case (state)
        IDLE: if (s2) begin
          state <= PRESS_FILTER;
          cnt <= '0;
        end
        PRESS_FILTER: if (!s2) begin
          state <= IDLE;
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          state <= HELD;
          cnt <= '0;
          key_posedge <= 1'b1;
          key_state <= 1'b1;
        end else cnt <= cnt + 1'b1;
        HELD: if (!s2) begin
          state <= RELEASE_FILTER;
          origin <= HELD;
          cnt <= '0;
        end else if (cnt == CW'(LONG_CYC - 1)) begin
          state <= LONG_HELD;
          cnt <= '0;
          key_long <= 1'b1;
        end else cnt <= cnt + 1'b1;
        LONG_HELD: if (!s2) begin
          state <= RELEASE_FILTER;
          origin <= LONG_HELD;
          cnt <= '0;
        end else if (!repeat_en) cnt <= '0;
        else if (cnt == CW'(REPEAT_CYC - 1)) begin
          cnt <= '0;
          key_repeat <= 1'b1;
        end else cnt <= cnt + 1'b1;
        // a release glitch resumes the origin state with a fresh count
        RELEASE_FILTER: if (s2) begin
          state <= origin;
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          state <= IDLE;
          cnt <= '0;
          key_negedge <= 1'b1;
          key_state <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/key_filter_array.sv
// key_filter_array: NUM_KEYS independent debounced key channels with long-press and auto-repeat.
module key_filter_array import key_filter_pkg::*; #(
  parameter int NUM_KEYS = 8,
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int LONG_CYC = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_posedge,
  output logic [NUM_KEYS-1:0] key_negedge,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);
  localparam int CW = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC(LONG_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .ACTIVE_LOW(ACTIVE_LOW),
      .CW(CW)
    ) u_ch (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_in(key_in[i]),
      .repeat_en(repeat_en[i]),
      .key_state(key_state[i]),
      .key_posedge(key_posedge[i]),
      .key_negedge(key_negedge[i]),
      .key_long(key_long[i]),
      .key_repeat(key_repeat[i])
    );
  end
endmodule

// File: tb/tb_key_filter_array.sv
// tb_key_filter_array: directed edge-by-edge checks of debounce, long-press, repeat and reset.
module tb_key_filter_array;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [3:0] key_in = '0;
  logic [3:0] repeat_en = '0;
  logic [3:0] key_state, key_posedge, key_negedge, key_long, key_repeat;
  logic [19:0] outs;
  int n_cmp = 0;
  int n_err = 0;

  key_filter_array #(
    .NUM_KEYS(4), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8), .ACTIVE_LOW(0)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in(key_in),
    .repeat_en(repeat_en),
    .key_state(key_state),
    .key_posedge(key_posedge),
    .key_negedge(key_negedge),
    .key_long(key_long),
    .key_repeat(key_repeat)
  );

  always #5 sys_clk = ~sys_clk;
  assign outs = {key_state, key_posedge, key_negedge, key_long, key_repeat};

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {st,pos,neg,long,rep}=%h expected %h", tag, obs, exp);
    end
  endtask

  // leaves the DUT out of reset 1 time unit after an edge; the next edge is edge 0
  task automatic do_reset();
    sys_rst_n = 1'b0;
    key_in = '0;
    repeat_en = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset", outs, '0);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // clean press on channel 0
    key_in = 4'b0001;
    for (int e = 0; e <= 12; e++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("press e=%0d", e), outs,
          {(e >= 6) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b0001 : 4'b0000, 12'h000});
    end
    // bouncing channel 1, then a stable hold from edge 30
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      key_in = (e >= 30 || e % 3 != 2) ? 4'b0010 : 4'b0000;
      @(posedge sys_clk); #1;
      chk($sformatf("bounce e=%0d", e), outs,
          {(e >= 36) ? 4'b0010 : 4'b0000, (e == 36) ? 4'b0010 : 4'b0000, 12'h000});
    end
    // long press with auto-repeat on channel 2
    do_reset();
    key_in = 4'b0100;
    repeat_en = 4'b0100;
    for (int e = 0; e <= 60; e++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("repeat e=%0d", e), outs,
          {(e >= 6) ? 4'b0100 : 4'b0000, (e == 6) ? 4'b0100 : 4'b0000, 4'b0000,
           (e == 26) ? 4'b0100 : 4'b0000,
           (e >= 34 && (e - 34) % 8 == 0) ? 4'b0100 : 4'b0000});
    end
    // long press without repeat, enable first seen at edge 41
    do_reset();
    key_in = 4'b0100;
    for (int e = 0; e <= 52; e++) begin
      repeat_en = (e >= 41) ? 4'b0100 : 4'b0000;
      @(posedge sys_clk); #1;
      chk($sformatf("norep e=%0d", e), outs,
          {(e >= 6) ? 4'b0100 : 4'b0000, (e == 6) ? 4'b0100 : 4'b0000, 4'b0000,
           (e == 26) ? 4'b0100 : 4'b0000, (e == 48) ? 4'b0100 : 4'b0000});
    end
    // channel 3: release glitch at edges 10-11, real release from edge 20
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      key_in = ((e >= 10 && e <= 11) || e >= 20) ? 4'b0000 : 4'b1000;
      @(posedge sys_clk); #1;
      chk($sformatf("release e=%0d", e), outs,
          {(e >= 6 && e < 26) ? 4'b1000 : 4'b0000, (e == 6) ? 4'b1000 : 4'b0000,
           (e == 26) ? 4'b1000 : 4'b0000, 8'h00});
    end
    // reset asserted mid-cycle while channel 0 is long-held
    do_reset();
    key_in = 4'b0001;
    for (int e = 0; e <= 30; e++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("pre-rst e=%0d", e), outs,
          {4'b0001 & {4{e >= 6}}, (e == 6) ? 4'b0001 : 4'b0000, 4'b0000,
           (e == 26) ? 4'b0001 : 4'b0000, 4'b0000});
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async rst", outs, '0);
    repeat (2) @(posedge sys_clk);
    #1;
    chk("in rst", outs, '0);
    sys_rst_n = 1'b1;
    for (int e = 0; e <= 30; e++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("post-rst e=%0d", e), outs,
          {4'b0001 & {4{e >= 6}}, (e == 6) ? 4'b0001 : 4'b0000, 4'b0000,
           (e == 26) ? 4'b0001 : 4'b0000, 4'b0000});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/key_filter_array.md
Name: key_filter_array

Overview:
- Parametrised multi-channel successor to the single-key debouncer.
- Debounces NUM_KEYS mechanical inputs (vending buttons and coin switches) in parallel.
- Per channel, provides a level output plus one-cycle press and release pulses, and adds long-press detection and auto-repeat.
- Sits between board pins and the vending state machine, replacing per-button debouncer instances.

Parameters:
- NUM_KEYS, 8, number of independent channels (≥1).
- DEBOUNCE_CYC, 2_000_000, stable cycles required to accept a press or release (20 ms at 100 MHz; ≥2).
- LONG_CYC, 100_000_000, held cycles after press acceptance before the long-press pulse (≥2).
- REPEAT_CYC, 20_000_000, auto-repeat period after long press (≥2).
- ACTIVE_LOW, 0, 1 means key_in is pressed-when-0; it is inverted at the input.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  asynchronous, active-low reset.
- key_in  input  NUM_KEYS  raw asynchronous key levels.
- repeat_en  input  NUM_KEYS  per-channel auto-repeat enable (synchronous to sys_clk).
- key_state  output  NUM_KEYS  debounced level, 1 = pressed.
- key_posedge  output  NUM_KEYS  one-cycle pulse on accepted press.
- key_negedge  output  NUM_KEYS  one-cycle pulse on accepted release.
- key_long  output  NUM_KEYS  one-cycle pulse when a press has lasted LONG_CYC.
- key_repeat  output  NUM_KEYS  one-cycle pulse every REPEAT_CYC while long-held and enabled.

Behaviour:
- Clock and reset: one clock, sys_clk; reset sys_rst_n is asynchronous and active-low.
- Reset: all outputs 0, every channel in IDLE, counters 0. The 2-FF synchronisers reset to the released level. A key held through reset therefore yields a fresh press after debounce.
- Input path: key_in (polarity-corrected) passes through a 2-FF synchroniser, s1 then s2; the FSM uses s2. A change sampled at edge e0 is visible to the FSM at edge e2.
- Counter: one counter per channel, width clog2(max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)). It is cleared on every state change.
- Outputs: all registered; pulses are exactly 1 cycle wide.
- IDLE: s2=1 -> PRESS_FILTER, cnt=0.
- PRESS_FILTER:
  - s2=0 -> IDLE, no output.
  - s2=1 and cnt==DEBOUNCE_CYC-1 -> HELD; pulse key_posedge; key_state=1.
  - Otherwise cnt++.
  - Press latency: posedge is asserted at edge e0+DEBOUNCE_CYC+2.
- HELD:
  - s2=0 -> RELEASE_FILTER; remember origin=HELD.
  - cnt==LONG_CYC-1 -> LONG_HELD; pulse key_long.
  - Otherwise cnt++.
- LONG_HELD:
  - s2=0 -> RELEASE_FILTER; remember origin=LONG_HELD.
  - repeat_en=1: cnt++; at cnt==REPEAT_CYC-1, pulse key_repeat and set cnt=0.
  - repeat_en=0: cnt held at 0, no repeat pulses. Re-enabling restarts a full REPEAT_CYC period.
- RELEASE_FILTER:
  - s2=1 -> return to origin state with cnt=0. Glitch rejected: no pulse, key_state stays 1.
  - s2=0 and cnt==DEBOUNCE_CYC-1 -> IDLE; pulse key_negedge; key_state=0.
- Pulse exclusivity: key_long and key_repeat never assert in the same cycle on one channel.
- Channels: fully independent; simultaneous events on different channels all pulse in the same cycle.
- Reset mid-operation: asynchronous; outputs drop to 0 without waiting for a clock edge. No negedge is emitted for a press that is aborted by reset.

Decomposition:
- Shared package key_filter_pkg:
  - channel state encoding: IDLE, PRESS_FILTER, HELD, LONG_HELD, RELEASE_FILTER;
  - a clog2 helper;
  - the counter-width derivation function.
- Sub-module key_filter_channel contains the synchroniser, FSM and counter for one key.
- The top instantiates NUM_KEYS copies in a generate loop.

Test Plan:
(NUM_KEYS=4, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, ACTIVE_LOW=0)
1. Clean press: key_in[0]=1 from edge 0, held -> key_posedge[0] pulse at edge 6 only; key_state[0]=1 from edge 6; other channels stay 0.
2. Bounce rejection: key_in[1] pattern 1,1,0,1,1,0 repeated for 30 cycles -> no key_posedge[1]. Then hold 1 -> posedge at last-rise+6.
3. Long press with repeat: repeat_en[2]=1, key_in[2] held 60 cycles from edge 0 -> posedge at 6, key_long at 26, key_repeat at 34, 42, 50, 58.
4. Long press without repeat: same stimulus with repeat_en[2]=0 -> posedge at 6, key_long at 26, no key_repeat. Asserting repeat_en at edge 40 -> first repeat at 48.
5. Release glitch then release: key_in[3] held into HELD, then 0 for 2 cycles -> no negedge, key_state[3]=1. Then key_in[3]=0 stable from edge r -> key_negedge[3] at r+6, key_state[3]=0.
6. Reset mid-LONG_HELD: channel 0 long-held, sys_rst_n low between edges -> all outputs 0 immediately. Release reset with key still held -> new posedge 6 edges after release, key_long 20 edges after that; no negedge observed.
